dm_arbiter: RTL

- Two-port arbiter/sequencer in front of the single-port data memory DM (clk, be, we, addr, wd, dr).
- Shares DM between requester 0 (CPU MEM stage or bridge) and requester 1 (DMA or debug port) using a req/gnt handshake.
- Sequences each access into DM's one-cycle synchronous-read timing and returns read data with a registered valid pulse.

---
 rtl/dm_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port req/gnt arbiter sequencing accesses into a one-cycle synchronous-read DM
// DM_ARBITER_RR_EN selects round-robin arbitration; undefined gives fixed m0 priority with starvation guard.
module dm_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rd,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_dr
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        rd_op_q, rd_op_d;
  logic        m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic        m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rd_q, m0_rd_d, m1_rd_q, m1_rd_d;
  logic        dm_we_q, dm_we_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_addr_q, dm_addr_d, dm_wd_q, dm_wd_d;
  logic        pick1;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr, sel_wd;

`ifdef DM_ARBITER_RR_EN
  logic ptr_q, ptr_d;
  assign pick1 = (m0_req & m1_req) ? ptr_q : m1_req;
`else
  logic [3:0] cnt_q, cnt_d;
  assign pick1 = m1_req & (~m0_req | (cnt_q == 4'(STARVE_MAX)));
`endif

  assign sel_we   = pick1 ? m1_we   : m0_we;
  assign sel_be   = pick1 ? m1_be   : m0_be;
  assign sel_addr = pick1 ? m1_addr : m0_addr;
  assign sel_wd   = pick1 ? m1_wd   : m0_wd;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    rd_op_d     = rd_op_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rd_d     = m0_rd_q;
    m1_rd_d     = m1_rd_q;
    dm_we_d     = 1'b0;
    dm_be_d     = 4'b0000;
    dm_addr_d   = 32'h0;
    dm_wd_d     = 32'h0;
`ifdef DM_ARBITER_RR_EN
    ptr_d       = ptr_q;
`else
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifndef DM_ARBITER_RR_EN
        if (!m1_req) cnt_d = 4'd0;
`endif
        if (m0_req | m1_req) begin
          // Outputs are registered, so the DM access is loaded here to appear during ACCESS.
          state_d   = ACCESS;
          win_d     = pick1;
          rd_op_d   = ~sel_we;
          m0_gnt_d  = ~pick1;
          m1_gnt_d  = pick1;
          dm_we_d   = sel_we & (|sel_be);
          dm_be_d   = sel_be;
          dm_addr_d = sel_addr & 32'hFFFF_FFFC;
          dm_wd_d   = sel_wd;
`ifdef DM_ARBITER_RR_EN
          if (m0_req & m1_req) ptr_d = ~pick1;
`else
          if (pick1) cnt_d = 4'd0;
          else if (m1_req && cnt_q != 4'(STARVE_MAX)) cnt_d = cnt_q + 4'd1;
`endif
        end
      end
      ACCESS: state_d = rd_op_q ? WAIT : IDLE;
      WAIT: begin
        state_d = IDLE;
        if (win_q) begin
          m1_rvalid_d = 1'b1;
          m1_rd_d     = dm_dr;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_rd_d     = dm_dr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      rd_op_q     <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rd_q     <= 32'h0;
      m1_rd_q     <= 32'h0;
      dm_we_q     <= 1'b0;
      dm_be_q     <= 4'b0000;
      dm_addr_q   <= 32'h0;
      dm_wd_q     <= 32'h0;
`ifdef DM_ARBITER_RR_EN
      ptr_q       <= 1'b0;
`else
      cnt_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rd_op_q     <= rd_op_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rd_q     <= m0_rd_d;
      m1_rd_q     <= m1_rd_d;
      dm_we_q     <= dm_we_d;
      dm_be_q     <= dm_be_d;
      dm_addr_q   <= dm_addr_d;
      dm_wd_q     <= dm_wd_d;
`ifdef DM_ARBITER_RR_EN
      ptr_q       <= ptr_d;
`else
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rd     = m0_rd_q;
  assign m1_rd     = m1_rd_q;
  assign dm_we     = dm_we_q;
  assign dm_be     = dm_be_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wd     = dm_wd_q;

endmodule
